q_max_scan_ctrl: RTL and testbench
==================================

Name: q_max_scan_ctrl

Overview:
- Controller that sequences the Q-value max/argmax search for one state of the Q-learning engine.
- On `start`, issues pipelined reads of the NUM_ACT Q-values of a state from the Q-table RAM and tracks the running maximum and its action index.
- Returns `q_max`/`a_max` with a done pulse. These feed the Q-update (max term) and greedy action-selection logic.

Parameters:
- NUM_ACT, 15, number of actions per state (1..16).
- STATE_W, 6, state index width.
- Q_W, 16, Q-value width, signed two's complement.
- RD_LAT, 1, Q-table read latency in cycles (1..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a scan; sampled only in IDLE.
- state_idx  in  STATE_W  state to scan; latched when start is accepted.
- action_mask  in  NUM_ACT  1 = action eligible; latched when start is accepted.
- busy  out  1  high from the cycle after acceptance through the done cycle.
- done  out  1  one-cycle pulse; results valid from this cycle.
- q_max  out  Q_W  maximum eligible Q-value.
- a_max  out  4  action index (0-based) of q_max.
- none_valid  out  1  high with done when the latched mask was all zero.
- mem_rd_en  out  1  Q-table read strobe.
- mem_addr  out  STATE_W+4  read address = {state, action[3:0]}.
- mem_rdata  in  Q_W  read data; valid RD_LAT cycles after mem_rd_en.

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE.
  - busy, done, mem_rd_en, none_valid = 0.
  - q_max = 0, a_max = 0, mem_addr = 0.
  - Internal counters and valid pipeline cleared.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 at edge T: latch state_idx and action_mask, init running max to most-negative (0x8000), seen flag = 0.
  - Go to ISSUE.
- ISSUE:
  - Cycles T+1..T+NUM_ACT: mem_rd_en=1, mem_addr={state, k} for k = 0..NUM_ACT-1, one per cycle, no bubbles.
  - After k = NUM_ACT-1, go to DRAIN.
- Read-data tracking:
  - Shift register of depth RD_LAT carries (valid, k) alongside each read.
  - mem_rdata for action k is compared in cycle T+1+k+RD_LAT.
- Compare rule:
  - Compare only if mask[k]=1.
  - Update when rdata > running max (signed), or when seen=0. Then set seen=1 and store k.
  - Ties keep the lower index (strict greater-than).
- DRAIN: wait RD_LAT cycles for the last data, then go to DONE.
- DONE (one cycle, T+NUM_ACT+RD_LAT+1):
  - done=1; q_max/a_max register the running result; none_valid = ~seen.
  - If seen=0: q_max=0x8000, a_max=0.
  - Return to IDLE.
- Latency: done at T+17 for NUM_ACT=15, RD_LAT=1.
- Outputs hold their values until the next done.
- busy=1 in ISSUE/DRAIN/DONE.
- start while busy: ignored, not queued.
- start high in the DONE cycle: ignored. A new scan may be accepted in the first IDLE cycle after done, giving a back-to-back period of NUM_ACT+RD_LAT+2 cycles.
- state_idx/action_mask changes while busy have no effect.
- Reset mid-scan: immediate abort to reset values; no done is produced.
- mem_rdata with no valid tag in flight is ignored.

Test Plan:
- Basic scan:
  - Setup: NUM_ACT=15, RD_LAT=1, state 3, mask all 1s. RAM {3,k} = k+1 except action 2 = 6.
  - Required: done exactly 17 cycles after start; q_max=15, a_max=14; mem_addr sequence 0x30..0x3E on consecutive cycles.
- Signed/negative values:
  - Setup: all entries negative (-100..-86), max -86 at k=14, with k=0 = -5.
  - Required: q_max=-5 (0xFFFB), a_max=0.
- Tie and mask:
  - Setup: actions 4 and 9 both = 200; mask clears action 11, which holds 500.
  - Required: q_max=200, a_max=4, none_valid=0.
- All masked:
  - Setup: mask=0.
  - Required: done with none_valid=1, q_max=0x8000, a_max=0.
- start while busy / back-to-back:
  - Stimulus: pulse start at cycle 5 of a scan; then start again right after done.
  - Required: the first pulse is ignored; the second scan is accepted and completes 17 cycles later with new-state results.
- Reset mid-scan and RD_LAT=3:
  - Stimulus: assert rst_n=0 during ISSUE.
  - Required: outputs are 0 immediately, there is no done, and the next scan is correct.
  - Repeat the basic scan with RD_LAT=3: done at T+19.

Source files
------------

// File: rtl/q_max_scan_ctrl_if.sv
// Q-table read port between the max/argmax scan controller (master) and the Q-table RAM (slave).
interface q_max_scan_ctrl_if #(
   parameter int STATE_W = 6,
   parameter int Q_W     = 16
);
   logic               mem_rd_en;
   logic [STATE_W+3:0] mem_addr;
   logic [Q_W-1:0]     mem_rdata;

   modport master (output mem_rd_en, output mem_addr, input mem_rdata);
   modport slave  (input mem_rd_en, input mem_addr, output mem_rdata);
endinterface

// File: rtl/q_max_scan_ctrl.sv
// Scans the NUM_ACT Q-values of one state with pipelined reads and returns
// the signed maximum over the eligible actions together with its action index.
module q_max_scan_ctrl #(
   parameter int NUM_ACT = 15,
   parameter int STATE_W = 6,
   parameter int Q_W     = 16,
   parameter int RD_LAT  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [STATE_W-1:0]   state_idx,
   input  logic [NUM_ACT-1:0]   action_mask,
   output logic                 busy,
   output logic                 done,
   output logic [Q_W-1:0]       q_max,
   output logic [3:0]           a_max,
   output logic                 none_valid,
   q_max_scan_ctrl_if.master    mem
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   localparam logic [3:0]     LAST_K = 4'(NUM_ACT - 1);
   localparam logic [Q_W-1:0] Q_MIN  = {1'b1, {(Q_W-1){1'b0}}};

   state_t             state_q, state_d;
   logic [STATE_W-1:0] st_q;
   logic [15:0]        mask_q;
   logic [3:0]         k_q;
   logic               rd_en_q;
   logic [STATE_W+3:0] addr_q;
   logic               vld_pipe [RD_LAT];
   logic [3:0]         tag_pipe [RD_LAT];
   logic [Q_W-1:0]     run_max_q;
   logic [3:0]         run_idx_q;
   logic               seen_q;

   logic               cmp_vld;
   logic [3:0]         cmp_k;
   logic               take;
   logic               last_cmp;
   logic [Q_W-1:0]     cand_max;
   logic [3:0]         cand_idx;
   logic               cand_seen;

   assign cmp_vld  = vld_pipe[RD_LAT-1];
   assign cmp_k    = tag_pipe[RD_LAT-1];
   assign take     = cmp_vld && mask_q[cmp_k] &&
                     (!seen_q || ($signed(mem.mem_rdata) > $signed(run_max_q)));
   assign last_cmp = cmp_vld && (cmp_k == LAST_K);

   // Running result including the compare happening this cycle, so the final
   // outputs can be registered on the same edge that consumes the last read.
   assign cand_max  = take ? mem.mem_rdata : run_max_q;
   assign cand_idx  = take ? cmp_k : run_idx_q;
   assign cand_seen = seen_q | take;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ISSUE;
         ISSUE:   if (k_q == LAST_K) state_d = DRAIN;
         DRAIN:   if (last_cmp) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q       <= '0;
         mask_q     <= '0;
         k_q        <= '0;
         rd_en_q    <= 1'b0;
         addr_q     <= '0;
         run_max_q  <= Q_MIN;
         run_idx_q  <= '0;
         seen_q     <= 1'b0;
         q_max      <= '0;
         a_max      <= '0;
         none_valid <= 1'b0;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            vld_pipe[i] <= 1'b0;
            tag_pipe[i] <= '0;
         end
      end else begin
         vld_pipe[0] <= rd_en_q;
         tag_pipe[0] <= addr_q[3:0];
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            tag_pipe[i] <= tag_pipe[i-1];
         end

         if (state_q == IDLE && start) begin
            st_q      <= state_idx;
            mask_q    <= 16'(action_mask);
            k_q       <= '0;
            rd_en_q   <= 1'b1;
            addr_q    <= {state_idx, 4'd0};
            run_max_q <= Q_MIN;
            run_idx_q <= '0;
            seen_q    <= 1'b0;
         end else begin
            run_max_q <= cand_max;
            run_idx_q <= cand_idx;
            seen_q    <= cand_seen;
            if (state_q == ISSUE) begin
               if (k_q == LAST_K) begin
                  rd_en_q <= 1'b0;
               end else begin
                  k_q    <= k_q + 4'd1;
                  addr_q <= {st_q, k_q + 4'd1};
               end
            end
         end

         // Unseen leaves run_max at Q_MIN and run_idx at 0, the required empty result.
         if (state_q == DRAIN && last_cmp) begin
            q_max      <= cand_max;
            a_max      <= cand_idx;
            none_valid <= ~cand_seen;
         end
      end
   end

   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DONE);
   assign mem.mem_rd_en = rd_en_q;
   assign mem.mem_addr  = addr_q;

endmodule

// File: tb/tb_q_max_scan_ctrl.sv
// Directed bench for q_max_scan_ctrl: one instance with RD_LAT=1 and one with RD_LAT=3,
// sharing a behavioural Q-table with hand-computed expected scan results.
module tb_q_max_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start1 = 1'b0;
   logic        start3 = 1'b0;
   logic [5:0]  state_idx = '0;
   logic [14:0] action_mask = '0;
   logic        sel3 = 1'b0;

   logic        busy1, done1, nv1, busy3, done3, nv3;
   logic [15:0] q1, q3;
   logic [3:0]  a1, a3;

   logic [15:0] ram [1024];
   logic [15:0] d1;
   logic [15:0] d3 [3];

   int n_checks = 0;
   int n_errors = 0;

   q_max_scan_ctrl_if #(.STATE_W(6), .Q_W(16)) if1 ();
   q_max_scan_ctrl_if #(.STATE_W(6), .Q_W(16)) if3 ();

   q_max_scan_ctrl #(.NUM_ACT(15), .STATE_W(6), .Q_W(16), .RD_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .state_idx(state_idx),
      .action_mask(action_mask), .busy(busy1), .done(done1), .q_max(q1),
      .a_max(a1), .none_valid(nv1), .mem(if1)
   );

   q_max_scan_ctrl #(.NUM_ACT(15), .STATE_W(6), .Q_W(16), .RD_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .state_idx(state_idx),
      .action_mask(action_mask), .busy(busy3), .done(done3), .q_max(q3),
      .a_max(a3), .none_valid(nv3), .mem(if3)
   );

   always #5 clk = ~clk;

   // Q-table models; 0x7FFF when no read is pending would win any compare if not ignored.
   always @(posedge clk) begin
      d1    <= if1.mem_rd_en ? ram[if1.mem_addr] : 16'h7FFF;
      d3[0] <= if3.mem_rd_en ? ram[if3.mem_addr] : 16'h7FFF;
      d3[1] <= d3[0];
      d3[2] <= d3[1];
   end
   assign if1.mem_rdata = d1;
   assign if3.mem_rdata = d3[2];

   logic        o_busy, o_done, o_nv, o_rd_en;
   logic [15:0] o_q;
   logic [3:0]  o_a;
   logic [9:0]  o_addr;
   assign o_busy  = sel3 ? busy3 : busy1;
   assign o_done  = sel3 ? done3 : done1;
   assign o_nv    = sel3 ? nv3 : nv1;
   assign o_q     = sel3 ? q3 : q1;
   assign o_a     = sel3 ? a3 : a1;
   assign o_rd_en = sel3 ? if3.mem_rd_en : if1.mem_rd_en;
   assign o_addr  = sel3 ? if3.mem_addr : if1.mem_addr;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic set_start(input bit l3, input logic v);
      if (l3) start3 = v;
      else    start1 = v;
   endtask

   // Interval i=1 is the first cycle after the accepting edge; done is due at i=16+RD_LAT.
   task automatic run_scan(input bit l3, input bit b2b, input bit poke,
                           input logic [5:0] st, input logic [14:0] msk,
                           input logic [15:0] eq, input logic [3:0] ea, input logic env);
      int  lat;
      int  i;
      bit  got_done;
      lat  = l3 ? 19 : 17;
      sel3 = l3;
      if (!b2b) @(negedge clk);
      state_idx   = st;
      action_mask = msk;
      set_start(l3, 1'b1);
      if (b2b) begin
         @(posedge clk); #1;
         check_val("start_in_done_ignored", 32'(o_busy), 32'd0);
      end
      @(posedge clk); #1;
      set_start(l3, 1'b0);
      state_idx   = ~st;
      action_mask = ~msk;
      check_val("busy_after_accept", 32'(o_busy), 32'd1);
      i = 0;
      got_done = 1'b0;
      while (!got_done && i < lat + 8) begin
         @(negedge clk);
         i++;
         if (i <= 15) begin
            check_val($sformatf("rd_en_k%0d", i - 1), 32'(o_rd_en), 32'd1);
            check_val($sformatf("addr_k%0d", i - 1), 32'(o_addr), 32'({st, 4'(i - 1)}));
         end else if (i == 16) begin
            check_val("rd_en_off", 32'(o_rd_en), 32'd0);
         end
         if (poke && i == 5) set_start(l3, 1'b1);
         if (poke && i == 6) set_start(l3, 1'b0);
         if (o_done) got_done = 1'b1;
      end
      check_val("done_seen", 32'(got_done), 32'd1);
      check_val("done_latency", 32'(i), 32'(lat));
      check_val("q_max", 32'(o_q), 32'(eq));
      check_val("a_max", 32'(o_a), 32'(ea));
      check_val("none_valid", 32'(o_nv), 32'(env));
      check_val("busy_at_done", 32'(o_busy), 32'd1);
   endtask

   initial begin
      for (int a = 0; a < 1024; a++) ram[a] = '0;
      for (int k = 0; k < 15; k++) begin
         ram[{6'd3, 4'(k)}]  = 16'(k + 1);
         ram[{6'd7, 4'(k)}]  = 16'(-100 + k);
         ram[{6'd9, 4'(k)}]  = 16'(k);
         ram[{6'd5, 4'(k)}]  = 16'(k);
         ram[{6'd10, 4'(k)}] = 16'h8000;
      end
      ram[{6'd3, 4'd2}]  = 16'd6;
      ram[{6'd7, 4'd0}]  = 16'hFFFB;
      ram[{6'd9, 4'd4}]  = 16'd200;
      ram[{6'd9, 4'd9}]  = 16'd200;
      ram[{6'd9, 4'd11}] = 16'd500;
      ram[{6'd5, 4'd8}]  = 16'd1000;

      #1;
      check_val("rst_busy", 32'(busy1), 32'd0);
      check_val("rst_done", 32'(done1), 32'd0);
      check_val("rst_q_max", 32'(q1), 32'd0);
      check_val("rst_a_max", 32'(a1), 32'd0);
      check_val("rst_none_valid", 32'(nv1), 32'd0);
      check_val("rst_rd_en", 32'(if1.mem_rd_en), 32'd0);
      check_val("rst_addr", 32'(if1.mem_addr), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      run_scan(1'b0, 1'b0, 1'b0, 6'd3, 15'h7FFF, 16'd15, 4'd14, 1'b0);
      @(negedge clk);
      check_val("done_one_cycle", 32'(done1), 32'd0);
      check_val("q_max_hold", 32'(q1), 32'd15);

      run_scan(1'b0, 1'b0, 1'b0, 6'd7, 15'h7FFF, 16'hFFFB, 4'd0, 1'b0);
      run_scan(1'b0, 1'b0, 1'b0, 6'd9, 15'h77FF, 16'd200, 4'd4, 1'b0);
      run_scan(1'b0, 1'b0, 1'b0, 6'd3, 15'h0000, 16'h8000, 4'd0, 1'b1);
      run_scan(1'b0, 1'b0, 1'b0, 6'd10, 15'h0040, 16'h8000, 4'd6, 1'b0);

      run_scan(1'b0, 1'b0, 1'b1, 6'd3, 15'h7FFF, 16'd15, 4'd14, 1'b0);
      run_scan(1'b0, 1'b1, 1'b0, 6'd5, 15'h7FFF, 16'd1000, 4'd8, 1'b0);

      sel3 = 1'b0;
      @(negedge clk);
      state_idx   = 6'd3;
      action_mask = 15'h7FFF;
      start1      = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("abort_busy", 32'(busy1), 32'd0);
      check_val("abort_done", 32'(done1), 32'd0);
      check_val("abort_q_max", 32'(q1), 32'd0);
      check_val("abort_a_max", 32'(a1), 32'd0);
      check_val("abort_none_valid", 32'(nv1), 32'd0);
      check_val("abort_rd_en", 32'(if1.mem_rd_en), 32'd0);
      check_val("abort_addr", 32'(if1.mem_addr), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (done1 !== 1'b0) check_val("no_done_after_abort", 32'(done1), 32'd0);
      end
      check_val("idle_after_abort", 32'(busy1), 32'd0);
      run_scan(1'b0, 1'b0, 1'b0, 6'd3, 15'h7FFF, 16'd15, 4'd14, 1'b0);

      run_scan(1'b1, 1'b0, 1'b0, 6'd3, 15'h7FFF, 16'd15, 4'd14, 1'b0);
      run_scan(1'b1, 1'b0, 1'b0, 6'd7, 15'h7FFF, 16'hFFFB, 4'd0, 1'b0);
      run_scan(1'b1, 1'b0, 1'b0, 6'd9, 15'h77FF, 16'd200, 4'd4, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
